// File: rtl/hex_display_scanner.sv
// Time-multiplexed scanner for a common-anode hex display: one nibble and one
// active-low anode per slot, shadow value committed only at frame boundaries.
module hex_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    load,
  input  logic                    blz_en,
  output logic [3:0]              digit,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pending;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    pend_valid;

  logic                  tick;
  logic                  boundary;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic [3:0]            cur_nib;
  logic                  blank;

  assign tick     = (cnt == CNT_MAX);
  assign boundary = tick && (idx == IDX_MAX);

  // lead_zero[i]: shadow nibbles i..NUM_DIGITS-1 are all zero
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (shadow[4*NUM_DIGITS-1 -: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lead_zero[i] = lead_zero[i+1] && (shadow[4*i +: 4] == 4'h0);
    end
  end

  assign cur_nib = shadow[4*int'(idx) +: 4];
  assign blank   = blz_en && (idx != '0) && lead_zero[idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      pending     <= '0;
      pend_valid  <= 1'b0;
      shadow      <= '0;
      digit       <= 4'h0;
      anode       <= '1;
      frame_start <= 1'b0;
    end else begin
      if (tick) begin
        cnt <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // A load coincident with the boundary beats any older pending value
      if (boundary) begin
        if (load)            shadow <= data_in;
        else if (pend_valid) shadow <= pending;
        pend_valid <= 1'b0;
      end else if (load) begin
        pending    <= data_in;
        pend_valid <= 1'b1;
      end

      digit       <= cur_nib;
      anode       <= (tick || blank) ? '1 : ~(NUM_DIGITS'(1) << idx);
      frame_start <= boundary;
    end
  end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Time-multiplexed driver for a common-anode multi-digit 7-segment display.
- Sits directly upstream of the per-digit hex-to-segment converter: holds a multi-digit hex value and scans one digit position at a time.
- Each scan slot presents that digit's nibble to the converter and drives the matching active-low anode.
- Provides tear-free value update at frame boundaries, leading-zero blanking and an anti-ghosting dead cycle.

Parameters:
NUM_DIGITS, 4, number of digit positions scanned (>=2)
REFRESH_DIV, 100000, clock cycles per digit slot (>=2); frame = NUM_DIGITS*REFRESH_DIV cycles

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
data_in  input  4*NUM_DIGITS  hex value to display; nibble i = digit position i (0 = rightmost)
load  input  1  one-cycle strobe: capture data_in for display from the next frame
blz_en  input  1  1 = blank leading zero digits
digit  output  4  nibble for the current slot, to the hex-to-segment converter
anode  output  NUM_DIGITS  active-low digit enables; at most one bit low at any time
frame_start  output  1  one-cycle pulse when slot 0 begins (shadow just committed)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- State: prescaler cnt (0..REFRESH_DIV-1), slot index idx (0..NUM_DIGITS-1), pending register + pend_valid, shadow register (displayed value).
- Reset: cnt=0, idx=0, pending=0, pend_valid=0, shadow=0, digit=0, anode=all ones, frame_start=0. Reset mid-frame discards pending and shadow immediately.
- Prescaler: cnt increments every cycle; at cnt==REFRESH_DIV-1 ("tick") cnt wraps to 0 and idx advances modulo NUM_DIGITS.
- Frame boundary: tick with idx==NUM_DIGITS-1.
  - If load is asserted the same cycle, shadow <= data_in.
  - Otherwise, if pend_valid, shadow <= pending.
  - pend_valid is cleared in both cases.
- Load away from a frame boundary: pending <= data_in, pend_valid <= 1. A later load before the boundary overwrites pending, so the last value wins.
- Blanking: slot i>0 is blanked when blz_en=1 and shadow nibbles i..NUM_DIGITS-1 are all zero. Slot 0 is never blanked, so value 0 shows a single "0".
- Outputs: registered, loaded every cycle from the current state, so they lag cnt/idx by exactly one cycle.
  - digit <= shadow nibble[idx].
  - anode <= all ones if cnt==REFRESH_DIV-1 (anti-ghost dead cycle) or slot idx is blanked; otherwise ~(1<<idx).
  - frame_start <= 1 when the frame boundary condition is true, else 0.
- Shadow update vs. outputs: a shadow update at a boundary is visible on digit in the first output cycle of slot 0. Within a frame, shadow never changes (no tearing).
- blz_en is sampled every cycle (not frame-latched); toggling it affects anode from the next cycle.

Test Plan:
- Reset, NUM_DIGITS=4, REFRESH_DIV=4, no load -> anode=4'b1111 during reset. First post-reset cycle: anode=4'b1110, digit=0. Anode pattern repeats 1110,1110,1110,1111,1101,... with one all-ones cycle per slot. Frame = 16 cycles; frame_start pulses every 16 cycles.
- load=1 with data_in=16'h1A2F mid-frame -> display unchanged until the frame boundary. Next frame slots 0..3 show digit=F,2,A,1 with anode 1110,1101,1011,0111.
- Two loads in one frame (16'h1111 then 16'h2222) -> next frame shows only 2222; load coincident with the boundary tick using 16'h3333 -> that same next frame shows 3333; pend_valid ends cleared.
- blz_en=1, shadow=16'h00A0 -> slots 0,1 drive anodes 1110/1101; slots 2,3 keep anode=4'b1111. shadow=16'h0000 -> only slot 0 is lit, digit=0. blz_en=0 -> all four slots lit.
- Reset asserted mid-frame with pend_valid=1 -> next cycle anode=4'b1111, shadow=0; after release the scan restarts at slot 0 and the pending value is never displayed.
- Assertion over the full run: anode never has more than one zero bit. Every slot transition includes exactly one all-ones cycle.
